tq_term_scheduler: RTL and testbench
====================================

// Module: tq_term_scheduler
// PURPOSE
//  Sequences term-quantized (exponent, sign) pairs into the coe_acc MAC chain, one term per cycle.
//  Enforces the per-group term budget: a group of group_size values may issue at most group_budget terms.
//  Excess terms are dropped and counted. The chain is drained before the group is reported done.
//  Sits between the term-encoder output stream and the mac array's input_selection/sign_ctrl inputs.
// PARAMETERS
//  NUM_BIT_EXPONENT   3  exponent width; mac_sel is NUM_BIT_EXPONENT+1 bits
//  NUM_COMBINED_TERMS 8  MAC chain depth; drain length in cycles
//  FIFO_DEPTH         8  term FIFO entries, power of 2, >=2
// PORTS
//  clk              in   1      clock, all logic on posedge
//  reset            in   1      synchronous, active-high
//  cfg_valid        in   1      group configuration offered
//  cfg_ready        out  1      high only in IDLE
//  cfg_group_size   in   5      values per group; 0 is treated as 1
//  cfg_group_budget in   7      max terms issued per group; 0 drops all terms
//  cfg_weight_exp   in   NBE    weight exponent added to every term of the group
//  term_valid       in   1      term offered
//  term_ready       out  1      !fifo_full
//  term_exp         in   NBE    term exponent
//  term_sign        in   1      1 = negative term
//  term_last        in   1      last term of the current value
//  mac_valid        out  1      mac_sel/mac_sign valid this cycle
//  mac_ready        in   1      mac accepts; outputs hold while mac_valid && !mac_ready
//  mac_sel          out  NBE+1  term_exp + cfg_weight_exp, zero-extended, no overflow
//  mac_sign         out  1      sign of issued term
//  grp_done         out  1      1-cycle pulse at end of DRAIN
//  grp_dropped      out  7      terms dropped in the last group; valid when grp_done is high, held until the next cfg handshake
//  busy             out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, all counters 0.
//  Reset outputs: mac_valid=0, mac_sel=0, mac_sign=0, grp_done=0, grp_dropped=0, busy=0.
//  Reset applied mid-group aborts the group with no grp_done pulse.
//  FSM states: IDLE, RUN, DROP, DRAIN.
//  IDLE->RUN on cfg_valid&&cfg_ready. Latch size, budget and weight_exp; clear val_cnt, term_cnt and drop_cnt.
//  RUN: pop one FIFO entry per cycle when FIFO is non-empty and the output register is free or draining.
//   Popped term is registered to mac_* with 1-cycle pop->mac_valid latency, then term_cnt++.
//   term_last popped: val_cnt++. If val_cnt reaches size, go to DRAIN.
//   term_cnt reaches budget with values outstanding: go to DROP.
//   Budget 0: go directly to DROP.
//  DROP: pop every cycle the FIFO is non-empty, mac_valid=0, drop_cnt++ (saturates at 127).
//   term_last popped on the final value: go to DRAIN.
//  DRAIN: wait for the last issued term to be accepted, then count NUM_COMBINED_TERMS cycles with mac_valid=0.
//   Then pulse grp_done, update grp_dropped, go to IDLE.
//  Term with term_last popped on the cycle budget is reached: the term is issued; if it was the final value go to DRAIN, else DROP.
//  FIFO push and pop in the same cycle: allowed when full, and count is unchanged. No pop when empty, so no underflow.
//  Terms arriving in IDLE are buffered; they are not popped until RUN.
//  Counters never wrap: term_cnt is bounded by budget, val_cnt by size.
// CONFIGURATION
//  TQ_SCHED_PAD_EN defined:
//   Adds output mac_pad (1 bit).
//   On entry to DRAIN, issue zero terms (mac_valid=1, mac_pad=1, mac_sel=0, mac_sign=0) until term_cnt == budget.
//   Each group then occupies a fixed budget issue slots.
//  TQ_SCHED_PAD_EN undefined: no mac_pad port, no padding.
// STRUCTURE
//  Package tq_pkg: EXP_W, SEL_W, GRP_SIZE_W=5, BUDGET_W=7, state enum tq_sched_state_e, term struct {exp, sign, last}.
//  Sub-module tq_term_fifo: synchronous FIFO of the term struct with full/empty flags, same clk and reset.
// TESTING
//  1 size=2, budget=4, wexp=1; terms (2,+,0)(3,-,1)(0,+,1) -> mac_sel 3,4,1; signs 0,1,0; drain 8; grp_done, dropped=0.
//  2 size=1, budget=2; 5 terms, last flag on the 5th -> 2 issued, grp_dropped=3, no mac_valid during DROP.
//  3 budget=0, size=1; 1 term with last -> zero mac_valid; grp_dropped=1; grp_done 8 cycles after the pop.
//  4 mac_ready low 3 cycles mid-group -> mac_sel/mac_sign held stable; no term lost or duplicated; FIFO fills, term_ready=0 at 8 entries.
//  5 reset asserted in RUN with 4 terms buffered -> next cycle all outputs 0, FIFO empty, busy=0, no grp_done.
//  6 PAD_EN, budget=4, 1 term issued -> 3 pad cycles (mac_pad=1, mac_sel=0), then drain, then grp_done.

Source files
------------

// File: rtl/tq_pkg.sv
// Shared widths, FSM encoding and term record for the term scheduler.
package tq_pkg;

    localparam int NUM_BIT_EXPONENT = 3;
    localparam int EXP_W            = NUM_BIT_EXPONENT;
    localparam int SEL_W            = EXP_W + 1;
    localparam int GRP_SIZE_W       = 5;
    localparam int BUDGET_W         = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DROP  = 2'd2,
        ST_DRAIN = 2'd3
    } tq_sched_state_e;

    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic             sign;
        logic             last;
    } term_t;

    // The extra select bit absorbs the carry, so the sum never overflows.
    function automatic logic [SEL_W-1:0] tq_sel(input logic [EXP_W-1:0] e, input logic [EXP_W-1:0] w);
        return SEL_W'(e) + SEL_W'(w);
    endfunction

endpackage

// File: rtl/tq_term_scheduler_if.sv
// Config, term-stream and MAC-side signals of the term scheduler; mac_pad exists only with TQ_SCHED_PAD_EN.
interface tq_term_scheduler_if;
    import tq_pkg::*;

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [GRP_SIZE_W-1:0] cfg_group_size;
    logic [BUDGET_W-1:0]   cfg_group_budget;
    logic [EXP_W-1:0]      cfg_weight_exp;
    logic                  term_valid;
    logic                  term_ready;
    logic [EXP_W-1:0]      term_exp;
    logic                  term_sign;
    logic                  term_last;
    logic                  mac_valid;
    logic                  mac_ready;
    logic [SEL_W-1:0]      mac_sel;
    logic                  mac_sign;
    logic                  grp_done;
    logic [BUDGET_W-1:0]   grp_dropped;
    logic                  busy;
`ifdef TQ_SCHED_PAD_EN
    logic                  mac_pad;
`endif

    modport master (
        output cfg_valid, cfg_group_size, cfg_group_budget, cfg_weight_exp,
        output term_valid, term_exp, term_sign, term_last, mac_ready,
        input  cfg_ready, term_ready, mac_valid, mac_sel, mac_sign,
        input  grp_done, grp_dropped, busy
`ifdef TQ_SCHED_PAD_EN
        , input mac_pad
`endif
    );

    modport slave (
        input  cfg_valid, cfg_group_size, cfg_group_budget, cfg_weight_exp,
        input  term_valid, term_exp, term_sign, term_last, mac_ready,
        output cfg_ready, term_ready, mac_valid, mac_sel, mac_sign,
        output grp_done, grp_dropped, busy
`ifdef TQ_SCHED_PAD_EN
        , output mac_pad
`endif
    );

endinterface

// File: rtl/tq_term_fifo.sv
// Synchronous FIFO of term records with show-ahead read data.
// Latency: a push is visible at the head one cycle later.
// Backpressure: full flag; a push while full is taken only together with a pop.
module tq_term_fifo
    import tq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  term_t push_dat,
    output logic  full,
    input  logic  pop,
    output term_t pop_dat,
    output logic  empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    term_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/tq_term_scheduler.sv
// Issues buffered terms to the MAC chain within a per-group budget, drops the excess, then drains; TQ_SCHED_PAD_EN pads groups to budget.
// Latency: FIFO pop to mac_valid is 1 cycle; grp_done follows NUM_COMBINED_TERMS idle cycles after the last issued term is accepted.
// Backpressure: mac_ready low holds mac_* and stops pops; term_ready falls when the term FIFO is full.
module tq_term_scheduler
    import tq_pkg::*;
#(
    parameter int NUM_COMBINED_TERMS = 8,
    parameter int FIFO_DEPTH         = 8
) (
    input logic                clk,
    input logic                reset,
    tq_term_scheduler_if.slave bus
);
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] RUN   = ST_RUN;
    localparam logic [1:0] DROP  = ST_DROP;
    localparam logic [1:0] DRAIN = ST_DRAIN;

    localparam int DR_W = $clog2(NUM_COMBINED_TERMS) + 1;
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(NUM_COMBINED_TERMS - 1);

    logic [1:0]            state;
    logic [GRP_SIZE_W-1:0] size_q;
    logic [BUDGET_W-1:0]   budget_q;
    logic [EXP_W-1:0]      wexp_q;
    logic [GRP_SIZE_W-1:0] val_cnt;
    logic [BUDGET_W-1:0]   term_cnt;
    logic [BUDGET_W-1:0]   drop_cnt;
    logic [DR_W-1:0]       drain_cnt;
    logic                  mac_valid_q;
    logic [SEL_W-1:0]      mac_sel_q;
    logic                  mac_sign_q;
    logic                  grp_done_q;
    logic [BUDGET_W-1:0]   grp_dropped_q;
`ifdef TQ_SCHED_PAD_EN
    logic                  mac_pad_q;
`endif

    term_t                 head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  out_free;
    logic                  run_pop;
    logic                  drop_pop;
    logic                  final_val;
    logic                  pad_issue;
    logic                  pad_done;
    logic [GRP_SIZE_W-1:0] val_cnt_inc;
    logic [BUDGET_W-1:0]   term_cnt_inc;

    tq_term_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (bus.term_valid && !fifo_full),
        .push_dat ('{exp: bus.term_exp, sign: bus.term_sign, last: bus.term_last}),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .pop_dat  (head),
        .empty    (fifo_empty)
    );

    assign out_free     = !mac_valid_q || bus.mac_ready;
    assign val_cnt_inc  = val_cnt + 1'b1;
    assign term_cnt_inc = term_cnt + 1'b1;
    assign final_val    = head.last && (val_cnt_inc == size_q);
    assign run_pop      = (state == RUN) && !fifo_empty && out_free && (term_cnt != budget_q);
    assign drop_pop     = (state == DROP) && !fifo_empty;
    assign fifo_pop     = run_pop || drop_pop;

`ifdef TQ_SCHED_PAD_EN
    assign pad_done  = (term_cnt == budget_q);
    assign pad_issue = (state == DRAIN) && out_free && !pad_done;
    assign bus.mac_pad = mac_pad_q;
`else
    assign pad_done  = 1'b1;
    assign pad_issue = 1'b0;
`endif

    assign bus.cfg_ready   = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.term_ready  = !fifo_full;
    assign bus.mac_valid   = mac_valid_q;
    assign bus.mac_sel     = mac_sel_q;
    assign bus.mac_sign    = mac_sign_q;
    assign bus.grp_done    = grp_done_q;
    assign bus.grp_dropped = grp_dropped_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            size_q        <= '0;
            budget_q      <= '0;
            wexp_q        <= '0;
            val_cnt       <= '0;
            term_cnt      <= '0;
            drop_cnt      <= '0;
            drain_cnt     <= '0;
            mac_valid_q   <= 1'b0;
            mac_sel_q     <= '0;
            mac_sign_q    <= 1'b0;
            grp_done_q    <= 1'b0;
            grp_dropped_q <= '0;
`ifdef TQ_SCHED_PAD_EN
            mac_pad_q     <= 1'b0;
`endif
        end else begin
            grp_done_q <= 1'b0;
            if (mac_valid_q && bus.mac_ready) mac_valid_q <= 1'b0;

            case (state)
                IDLE: if (bus.cfg_valid) begin
                    size_q        <= (bus.cfg_group_size == '0) ? GRP_SIZE_W'(1) : bus.cfg_group_size;
                    budget_q      <= bus.cfg_group_budget;
                    wexp_q        <= bus.cfg_weight_exp;
                    val_cnt       <= '0;
                    term_cnt      <= '0;
                    drop_cnt      <= '0;
                    drain_cnt     <= '0;
                    grp_dropped_q <= '0;
                    state         <= RUN;
                end
                RUN: if (budget_q == '0) begin
                    state <= DROP;
                end else if (run_pop) begin
                    mac_valid_q <= 1'b1;
                    mac_sel_q   <= tq_sel(head.exp, wexp_q);
                    mac_sign_q  <= head.sign;
`ifdef TQ_SCHED_PAD_EN
                    mac_pad_q   <= 1'b0;
`endif
                    term_cnt    <= term_cnt_inc;
                    if (head.last) val_cnt <= val_cnt_inc;
                    // The final value wins over budget exhaustion: nothing is left to drop.
                    if (final_val)                      state <= DRAIN;
                    else if (term_cnt_inc == budget_q)  state <= DROP;
                end
                DROP: if (drop_pop) begin
                    if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
                    if (head.last)      val_cnt  <= val_cnt_inc;
                    if (final_val)      state    <= DRAIN;
                end
                DRAIN: if (pad_issue) begin
                    mac_valid_q <= 1'b1;
                    mac_sel_q   <= '0;
                    mac_sign_q  <= 1'b0;
`ifdef TQ_SCHED_PAD_EN
                    mac_pad_q   <= 1'b1;
`endif
                    term_cnt    <= term_cnt_inc;
                end else if (pad_done && !mac_valid_q) begin
                    if (drain_cnt == DR_LAST) begin
                        grp_done_q    <= 1'b1;
                        grp_dropped_q <= drop_cnt;
                        drain_cnt     <= '0;
                        state         <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tq_term_scheduler.sv
// Directed bench for tq_term_scheduler; padding expectations follow TQ_SCHED_PAD_EN.
module tb_tq_term_scheduler;
    import tq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

`ifdef TQ_SCHED_PAD_EN
    localparam int PAD1 = 1;
`else
    localparam int PAD1 = 0;
`endif

    tq_term_scheduler_if bif();

    tq_term_scheduler #(.NUM_COMBINED_TERMS(8), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_term(input int e, input bit s, input bit l);
        bif.term_valid = 1'b1;
        bif.term_exp   = EXP_W'(e);
        bif.term_sign  = s;
        bif.term_last  = l;
        step();
        bif.term_valid = 1'b0;
    endtask

    task automatic start_group(input int size, input int budget, input int wexp);
        bif.cfg_valid        = 1'b1;
        bif.cfg_group_size   = GRP_SIZE_W'(size);
        bif.cfg_group_budget = BUDGET_W'(budget);
        bif.cfg_weight_exp   = EXP_W'(wexp);
        step();
        bif.cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_steps);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (bif.grp_done !== 1'b1 && n < 200);
        chk(tag, n, exp_steps);
    endtask

    initial begin
        reset = 1'b1;
        bif.cfg_valid = 1'b0;
        bif.cfg_group_size = '0;
        bif.cfg_group_budget = '0;
        bif.cfg_weight_exp = '0;
        bif.term_valid = 1'b0;
        bif.term_exp = '0;
        bif.term_sign = 1'b0;
        bif.term_last = 1'b0;
        bif.mac_ready = 1'b1;
        step();
        step();
        chk("rst_mac_valid", bif.mac_valid, 0);
        chk("rst_mac_sel", bif.mac_sel, 0);
        chk("rst_mac_sign", bif.mac_sign, 0);
        chk("rst_grp_done", bif.grp_done, 0);
        chk("rst_grp_dropped", bif.grp_dropped, 0);
        chk("rst_busy", bif.busy, 0);
        chk("rst_cfg_ready", bif.cfg_ready, 1);
        chk("rst_term_ready", bif.term_ready, 1);
        reset = 1'b0;
        step();

        // 1: size 2, budget 4, wexp 1
        push_term(2, 0, 0);
        push_term(3, 1, 1);
        push_term(0, 0, 1);
        chk("t1_idle_no_issue", bif.mac_valid, 0);
        start_group(2, 4, 1);
        chk("t1_busy", bif.busy, 1);
        chk("t1_cfg_ready", bif.cfg_ready, 0);
        step();
        chk("t1_v0", bif.mac_valid, 1); chk("t1_sel0", bif.mac_sel, 3); chk("t1_sign0", bif.mac_sign, 0);
        step();
        chk("t1_v1", bif.mac_valid, 1); chk("t1_sel1", bif.mac_sel, 4); chk("t1_sign1", bif.mac_sign, 1);
        step();
        chk("t1_v2", bif.mac_valid, 1); chk("t1_sel2", bif.mac_sel, 1); chk("t1_sign2", bif.mac_sign, 0);
        step();
        chk("t1_after_last", bif.mac_valid, PAD1);
        wait_done("t1_drain_len", 8 + PAD1);
        chk("t1_dropped", bif.grp_dropped, 0);
        chk("t1_idle", bif.busy, 0);
        step();
        chk("t1_done_pulse", bif.grp_done, 0);

        // 2: size 1, budget 2, five terms
        for (int i = 1; i <= 5; i++) push_term(i, i[0], i == 5);
        start_group(1, 2, 0);
        step();
        chk("t2_v0", bif.mac_valid, 1); chk("t2_sel0", bif.mac_sel, 1); chk("t2_sign0", bif.mac_sign, 1);
        step();
        chk("t2_v1", bif.mac_valid, 1); chk("t2_sel1", bif.mac_sel, 2); chk("t2_sign1", bif.mac_sign, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t2_drop_quiet%0d", i), bif.mac_valid, 0);
        end
        wait_done("t2_drain_len", 8);
        chk("t2_dropped", bif.grp_dropped, 3);
        step();
        chk("t2_dropped_held", bif.grp_dropped, 3);
        chk("t2_done_pulse", bif.grp_done, 0);

        // 3: budget 0 drops everything
        push_term(6, 1, 1);
        start_group(1, 0, 0);
        chk("t3_q0", bif.mac_valid, 0);
        step();
        chk("t3_q1", bif.mac_valid, 0);
        step();
        chk("t3_q2", bif.mac_valid, 0);
        wait_done("t3_drain_len", 8);
        chk("t3_dropped", bif.grp_dropped, 1);

        // 4: FIFO fill, then a 3-cycle stall mid-group
        step();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("t4_ready_at7", bif.term_ready, 1);
            push_term(i, i[0], i == 7);
        end
        chk("t4_full_ready", bif.term_ready, 0);
        start_group(1, 20, 0);
        step();
        chk("t4_v0", bif.mac_valid, 1); chk("t4_sel0", bif.mac_sel, 0);
        bif.mac_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t4_hold_v%0d", i), bif.mac_valid, 1);
            chk($sformatf("t4_hold_sel%0d", i), bif.mac_sel, 0);
            chk($sformatf("t4_hold_sign%0d", i), bif.mac_sign, 0);
        end
        bif.mac_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("t4_v%0d", i), bif.mac_valid, 1);
            chk($sformatf("t4_sel%0d", i), bif.mac_sel, i);
            chk($sformatf("t4_sign%0d", i), bif.mac_sign, i & 1);
        end
        wait_done("t4_drain_len", 9 + 12 * PAD1);
        chk("t4_dropped", bif.grp_dropped, 0);

        // 5: reset in RUN with four terms buffered
        step();
        bif.mac_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_term(i, 0, 0);
        start_group(2, 10, 0);
        step();
        chk("t5_busy", bif.busy, 1);
        chk("t5_v0", bif.mac_valid, 1);
        reset = 1'b1;
        step();
        chk("t5_mac_valid", bif.mac_valid, 0);
        chk("t5_mac_sel", bif.mac_sel, 0);
        chk("t5_mac_sign", bif.mac_sign, 0);
        chk("t5_grp_done", bif.grp_done, 0);
        chk("t5_busy_clr", bif.busy, 0);
        chk("t5_term_ready", bif.term_ready, 1);
        step();
        chk("t5_grp_done2", bif.grp_done, 0);
        reset = 1'b0;
        bif.mac_ready = 1'b1;
        start_group(1, 4, 2);
        step();
        chk("t5_empty0", bif.mac_valid, 0);
        step();
        chk("t5_empty1", bif.mac_valid, 0);
        push_term(5, 1, 1);
        chk("t5_empty2", bif.mac_valid, 0);
        step();
        chk("t6_v0", bif.mac_valid, 1); chk("t6_sel0", bif.mac_sel, 7); chk("t6_sign0", bif.mac_sign, 1);
`ifdef TQ_SCHED_PAD_EN
        chk("t6_pad_real", bif.mac_pad, 0);
        // 6: budget 4 with one real term leaves three pad slots
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t6_pad_v%0d", i), bif.mac_valid, 1);
            chk($sformatf("t6_pad%0d", i), bif.mac_pad, 1);
            chk($sformatf("t6_pad_sel%0d", i), bif.mac_sel, 0);
            chk($sformatf("t6_pad_sign%0d", i), bif.mac_sign, 0);
        end
`endif
        wait_done("t6_drain_len", 9);
        chk("t6_dropped", bif.grp_dropped, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
